// File: rtl/alu_mc.sv
// Multi-cycle ALU: legacy single-cycle ops plus iterative signed/unsigned
// multiply and divide behind a valid/ready handshake with registered outputs.
module alu_mc #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [3:0]   ALUctr,
    output logic         out_valid,
    output logic [N-1:0] Result,
    output logic [N-1:0] ResultHi,
    output logic         Zero,
    output logic         Overflow,
    output logic         DivZero
);
    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;          // {is_div, is_signed}
    logic [N-1:0]  acc_q, acc_d;        // product high half / partial remainder
    logic [N-1:0]  mq_q, mq_d;          // multiplier -> product low / dividend -> quotient
    logic [N-1:0]  mc_q, mc_d;          // multiplicand magnitude / divisor magnitude
    logic [N-1:0]  araw_q, araw_d;
    logic          neg_q, neg_d, rneg_q, rneg_d, dz_q, dz_d;
    logic [N-1:0]  res_q, res_d, resh_q, resh_d;
    logic          zero_q, zero_d, ovf_q, ovf_d, dzf_q, dzf_d;

    logic [N-1:0]   sum, dif, sc_res, abs_a, abs_b;
    logic           sc_ovf, sc_zero;
    logic [N:0]     mul_sum, div_sh, div_dif;
    logic [2*N-1:0] prod_mag, prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;

    assign sum = A + B;
    assign dif = A - B;

    always_comb begin
        sc_res = '0;
        sc_ovf = 1'b0;
        case (ALUctr)
            4'b0000: sc_res = sum;
            4'b0001: begin
                sc_res = sum;
                sc_ovf = (A[N-1] == B[N-1]) && (sum[N-1] != A[N-1]);
            end
            4'b0010: sc_res = A | B;
            4'b0011: sc_res = A & B;
            4'b0100: sc_res = dif;
            4'b0101: begin
                sc_res = dif;
                sc_ovf = (A[N-1] != B[N-1]) && (dif[N-1] != A[N-1]);
            end
            4'b0110: sc_res = {{(N-1){1'b0}}, A < B};
            4'b0111: sc_res = {{(N-1){1'b0}}, $signed(A) < $signed(B)};
            default: sc_res = '0;
        endcase
        sc_zero = !ALUctr[3] && (sc_res == '0);
    end

    assign abs_a = (ALUctr[0] && A[N-1]) ? ('0 - A) : A;
    assign abs_b = (ALUctr[0] && B[N-1]) ? ('0 - B) : B;

    assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mc_q} : '0);
    assign div_sh  = {acc_q, mq_q[N-1]};
    assign div_dif = div_sh - {1'b0, mc_q};

    assign prod_mag = {acc_q, mq_q};
    assign prod_fix = neg_q ? ('0 - prod_mag) : prod_mag;
    assign quo_fix  = neg_q ? ('0 - mq_q) : mq_q;
    assign rem_fix  = rneg_q ? ('0 - acc_q) : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        mc_d    = mc_q;
        araw_d  = araw_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        res_d   = res_q;
        resh_d  = resh_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        dzf_d   = dzf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (ALUctr[3:2] == 2'b10) begin
                        op_d    = ALUctr[1:0];
                        acc_d   = '0;
                        cnt_d   = CW'(N);
                        araw_d  = A;
                        dz_d    = (B == '0);
                        neg_d   = ALUctr[0] && (A[N-1] ^ B[N-1]);
                        rneg_d  = ALUctr[0] && ALUctr[1] && A[N-1];
                        mq_d    = ALUctr[1] ? abs_a : abs_b;
                        mc_d    = ALUctr[1] ? abs_b : abs_a;
                        state_d = ITER;
                    end else begin
                        res_d   = sc_res;
                        resh_d  = '0;
                        zero_d  = sc_zero;
                        ovf_d   = sc_ovf;
                        dzf_d   = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            ITER: begin
                if (op_q[1]) begin
                    // Restoring step: keep the difference only if it did not borrow.
                    if (!div_dif[N]) begin
                        acc_d = div_dif[N-1:0];
                        mq_d  = {mq_q[N-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[N-1:0];
                        mq_d  = {mq_q[N-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[N:1];
                    mq_d  = {mul_sum[0], mq_q[N-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (op_q[1]) begin
                    if (dz_q) begin
                        res_d  = '1;
                        resh_d = araw_q;
                        zero_d = 1'b0;
                        ovf_d  = 1'b0;
                        dzf_d  = 1'b1;
                    end else begin
                        res_d  = quo_fix;
                        resh_d = rem_fix;
                        zero_d = (quo_fix == '0);
                        // Only MIN / -1 yields a positive quotient magnitude of 2^(N-1).
                        ovf_d  = op_q[0] && !neg_q && mq_q[N-1];
                        dzf_d  = 1'b0;
                    end
                end else begin
                    res_d  = prod_fix[N-1:0];
                    resh_d = prod_fix[2*N-1:N];
                    zero_d = (prod_fix[N-1:0] == '0);
                    ovf_d  = op_q[0] ? (prod_fix[2*N-1:N] != {N{prod_fix[N-1]}})
                                     : (prod_fix[2*N-1:N] != '0);
                    dzf_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            mc_q    <= '0;
            araw_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            res_q   <= '0;
            resh_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dzf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            mc_q    <= mc_d;
            araw_q  <= araw_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            res_q   <= res_d;
            resh_q  <= resh_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dzf_q   <= dzf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Result    = res_q;
    assign ResultHi  = resh_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign DivZero   = dzf_q;
endmodule
